// File: rtl/pong_game_core.sv
// pong_game_core: two-player Pong game state on a cell grid.
//
// Holds both paddles, the ball, the scores and the game FSM
// (SERVE -> PLAY -> POINT -> SERVE/GAME_OVER), and flags whether the
// pixel currently being drawn lies on a paddle or on the ball.
//
// Ports
//   clk                        system clock, all state on the rising edge
//   reset                      asynchronous, active-low reset
//   frame_tick                 one-cycle pulse per video frame
//   up_l/down_l/up_r/down_r    paddle buttons (already synchronised)
//   serve                      one-cycle serve / restart request
//   hori_cell, vert_cell       pixel position being drawn, in cells
//   on_paddle_l/on_paddle_r    pixel lies on the left / right paddle
//   on_ball                    pixel lies on the ball (SERVE or PLAY only)
//   score_l, score_r           current scores
//   state                      SERVE=0, PLAY=1, POINT=2, GAME_OVER=3
//
// Handshake: serve and frame_tick are single-cycle strobes sampled on the
// rising clock edge; there is no backpressure, so a strobe that arrives in
// a state that does not use it is simply dropped.
module pong_game_core #(
    parameter int GRID_W       = 40,
    parameter int GRID_H       = 30,
    parameter int PADDLE_LEN   = 6,
    parameter int PADDLE_L_COL = 0,
    parameter int PADDLE_R_COL = 39,
    parameter int BALL_DIV     = 4,
    parameter int POINT_FRAMES = 60,
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               up_l,
    input  logic               down_l,
    input  logic               up_r,
    input  logic               down_r,
    input  logic               serve,
    input  logic [9:0]         hori_cell,
    input  logic [9:0]         vert_cell,
    output logic               on_paddle_l,
    output logic               on_paddle_r,
    output logic               on_ball,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        ST_SERVE     = 2'd0,
        ST_PLAY      = 2'd1,
        ST_POINT     = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    localparam int STEP_W  = (BALL_DIV > 1) ? $clog2(BALL_DIV) : 1;
    localparam int POINT_W = (POINT_FRAMES > 1) ? $clog2(POINT_FRAMES) : 1;

    localparam logic [9:0]         PAD_MAX    = 10'(GRID_H - PADDLE_LEN);
    localparam logic [9:0]         PAD_INIT   = 10'((GRID_H - PADDLE_LEN) / 2);
    localparam logic [9:0]         PAD_SPAN   = 10'(PADDLE_LEN - 1);
    localparam logic [9:0]         BALL_X0    = 10'(GRID_W / 2);
    localparam logic [9:0]         BALL_Y0    = 10'(GRID_H / 2);
    localparam logic [9:0]         Y_MAX      = 10'(GRID_H - 1);
    localparam logic [9:0]         COL_L      = 10'(PADDLE_L_COL);
    localparam logic [9:0]         COL_R      = 10'(PADDLE_R_COL);
    localparam logic [9:0]         X_HIT_L    = 10'(PADDLE_L_COL + 1);
    localparam logic [9:0]         X_HIT_R    = 10'(PADDLE_R_COL - 1);
    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(BALL_DIV - 1);
    localparam logic [POINT_W-1:0] POINT_LAST = POINT_W'(POINT_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

    state_t               state_q, state_d;
    logic [9:0]           paddle_l_q, paddle_l_d, paddle_r_q, paddle_r_d;
    logic [9:0]           ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic                 dx_q, dx_d;   // 1 = moving right
    logic                 dy_q, dy_d;   // 1 = moving down
    logic [STEP_W-1:0]    step_cnt_q, step_cnt_d;
    logic [POINT_W-1:0]   point_cnt_q, point_cnt_d;
    logic [SCORE_W-1:0]   score_l_q, score_l_d, score_r_q, score_r_d;

    // Candidate ball step, evaluated every cycle and used only on a step tick.
    logic [9:0] next_x, next_y;
    logic       next_dx, next_dy, miss_l, miss_r, hit_l, hit_r;

    function automatic logic [9:0] paddle_next(input logic [9:0] top,
                                               input logic up, input logic down);
        logic [9:0] nxt;
        nxt = top;
        if (up && !down && top != 10'd0)
            nxt = top - 10'd1;
        else if (down && !up && top != PAD_MAX)
            nxt = top + 10'd1;
        return nxt;
    endfunction

    // Collisions are judged against the registered (pre-update) paddles.
    assign hit_l = (ball_y_q >= paddle_l_q) && (ball_y_q <= paddle_l_q + PAD_SPAN);
    assign hit_r = (ball_y_q >= paddle_r_q) && (ball_y_q <= paddle_r_q + PAD_SPAN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_SERVE;
            paddle_l_q  <= PAD_INIT;
            paddle_r_q  <= PAD_INIT;
            ball_x_q    <= BALL_X0;
            ball_y_q    <= BALL_Y0;
            dx_q        <= 1'b1;
            dy_q        <= 1'b1;
            step_cnt_q  <= '0;
            point_cnt_q <= '0;
            score_l_q   <= '0;
            score_r_q   <= '0;
        end else begin
            state_q     <= state_d;
            paddle_l_q  <= paddle_l_d;
            paddle_r_q  <= paddle_r_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            step_cnt_q  <= step_cnt_d;
            point_cnt_q <= point_cnt_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        paddle_l_d  = paddle_l_q;
        paddle_r_d  = paddle_r_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        step_cnt_d  = step_cnt_q;
        point_cnt_d = point_cnt_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        next_x      = ball_x_q;
        next_y      = ball_y_q;
        next_dx     = dx_q;
        next_dy     = dy_q;
        miss_l      = 1'b0;
        miss_r      = 1'b0;

        // Vertical: bounce off top/bottom walls, landing one row inside.
        if (!dy_q && ball_y_q == 10'd0) begin
            next_dy = 1'b1;
            next_y  = 10'd1;
        end else if (dy_q && ball_y_q == Y_MAX) begin
            next_dy = 1'b0;
            next_y  = Y_MAX - 10'd1;
        end else if (dy_q) begin
            next_y = ball_y_q + 10'd1;
        end else begin
            next_y = ball_y_q - 10'd1;
        end

        // Horizontal: the column next to a paddle either returns or misses.
        if (dx_q && ball_x_q == X_HIT_R) begin
            if (hit_r) begin
                next_dx = 1'b0;
                next_x  = ball_x_q - 10'd1;
            end else begin
                miss_r = 1'b1;
            end
        end else if (!dx_q && ball_x_q == X_HIT_L) begin
            if (hit_l) begin
                next_dx = 1'b1;
                next_x  = ball_x_q + 10'd1;
            end else begin
                miss_l = 1'b1;
            end
        end else if (dx_q) begin
            next_x = ball_x_q + 10'd1;
        end else begin
            next_x = ball_x_q - 10'd1;
        end

        if (frame_tick && state_q != ST_GAME_OVER) begin
            paddle_l_d = paddle_next(paddle_l_q, up_l, down_l);
            paddle_r_d = paddle_next(paddle_r_q, up_r, down_r);
        end

        case (state_q)
            ST_SERVE: begin
                // A tick arriving with serve is not counted toward the first step.
                if (serve)
                    state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (frame_tick) begin
                    if (step_cnt_q == STEP_LAST) begin
                        step_cnt_d = '0;
                        if (miss_l || miss_r) begin
                            // Ball freezes; dx keeps pointing at the conceding side.
                            state_d     = ST_POINT;
                            point_cnt_d = '0;
                            if (miss_r)
                                score_l_d = score_l_q + SCORE_W'(1);
                            else
                                score_r_d = score_r_q + SCORE_W'(1);
                        end else begin
                            ball_x_d = next_x;
                            ball_y_d = next_y;
                            dx_d     = next_dx;
                            dy_d     = next_dy;
                        end
                    end else begin
                        step_cnt_d = step_cnt_q + STEP_W'(1);
                    end
                end
            end
            ST_POINT: begin
                if (frame_tick) begin
                    if (point_cnt_q == POINT_LAST) begin
                        point_cnt_d = '0;
                        if (score_l_q == WIN || score_r_q == WIN) begin
                            state_d = ST_GAME_OVER;
                        end else begin
                            state_d  = ST_SERVE;
                            ball_x_d = BALL_X0;
                            ball_y_d = BALL_Y0;
                            dy_d     = 1'b1;
                        end
                    end else begin
                        point_cnt_d = point_cnt_q + POINT_W'(1);
                    end
                end
            end
            ST_GAME_OVER: begin
                if (serve) begin
                    state_d   = ST_SERVE;
                    score_l_d = '0;
                    score_r_d = '0;
                    ball_x_d  = BALL_X0;
                    ball_y_d  = BALL_Y0;
                    dx_d      = 1'b1;
                    dy_d      = 1'b1;
                end
            end
            default: state_d = ST_SERVE;
        endcase
    end

    assign on_paddle_l = (hori_cell == COL_L) && (vert_cell >= paddle_l_q) &&
                         (vert_cell <= paddle_l_q + PAD_SPAN);
    assign on_paddle_r = (hori_cell == COL_R) && (vert_cell >= paddle_r_q) &&
                         (vert_cell <= paddle_r_q + PAD_SPAN);
    assign on_ball     = (state_q == ST_SERVE || state_q == ST_PLAY) &&
                         (hori_cell == ball_x_q) && (vert_cell == ball_y_q);
    assign score_l     = score_l_q;
    assign score_r     = score_r_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pong_game_core.sv
// tb_pong_game_core: self-checking bench for pong_game_core.
// A behavioural game model (signed positions, direction as +1/-1, wall
// reflection by negating the velocity) runs beside the DUT; every cycle the
// scores, state and pixel flags at the ball and around both paddles are
// compared. Directed scenarios cover the scripted rallies, paddle limits,
// an asynchronous reset pulse and a full pixel sweep; a randomized bot
// match plays a game through to GAME_OVER.
module tb_pong_game_core;

    localparam int GRID_W       = 40;
    localparam int GRID_H       = 30;
    localparam int PADDLE_LEN   = 6;
    localparam int PADDLE_L_COL = 0;
    localparam int PADDLE_R_COL = 39;
    localparam int BALL_DIV     = 4;
    localparam int POINT_FRAMES = 60;
    localparam int SCORE_W      = 4;
    localparam int WIN_SCORE    = 9;
    localparam int PAD_MAX      = GRID_H - PADDLE_LEN;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               frame_tick = 1'b0, serve = 1'b0;
    logic               up_l = 1'b0, down_l = 1'b0, up_r = 1'b0, down_r = 1'b0;
    logic [9:0]         hori_cell = '0, vert_cell = '0;
    logic               on_paddle_l, on_paddle_r, on_ball;
    logic [SCORE_W-1:0] score_l, score_r;
    logic [1:0]         state;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int m_state, m_bx, m_by, m_dx, m_dy, m_pl, m_pr, m_sl, m_sr, m_ticks;
    bit m_conceded_right;

    pong_game_core dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .up_l(up_l), .down_l(down_l), .up_r(up_r), .down_r(down_r),
        .serve(serve), .hori_cell(hori_cell), .vert_cell(vert_cell),
        .on_paddle_l(on_paddle_l), .on_paddle_r(on_paddle_r), .on_ball(on_ball),
        .score_l(score_l), .score_r(score_r), .state(state)
    );

    // Clock
    always #10 clk = ~clk;

    // Watchdog
    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic center_ball();
        m_bx = GRID_W / 2;
        m_by = GRID_H / 2;
        m_dy = 1;
    endtask

    task automatic model_reset();
        m_state = 0;
        center_ball();
        m_dx = 1;
        m_pl = PAD_MAX / 2;
        m_pr = PAD_MAX / 2;
        m_sl = 0;
        m_sr = 0;
        m_ticks = 0;
        m_conceded_right = 1'b1;
    endtask

    function automatic int clamp_pad(input int v);
        if (v < 0) return 0;
        if (v > PAD_MAX) return PAD_MAX;
        return v;
    endfunction

    task automatic model_ball_step(input int pl0, input int pr0);
        int nx, ny, ndx, ndy;
        bit miss_right, miss_left;
        ndy = m_dy;
        ny  = m_by + ndy;
        if (ny < 0 || ny > GRID_H - 1) begin
            ndy = -ndy;
            ny  = m_by + ndy;
        end
        ndx = m_dx;
        nx  = m_bx + ndx;
        miss_right = 1'b0;
        miss_left  = 1'b0;
        if (nx == PADDLE_R_COL) begin
            if (m_by >= pr0 && m_by < pr0 + PADDLE_LEN) begin
                ndx = -ndx;
                nx  = m_bx + ndx;
            end else miss_right = 1'b1;
        end else if (nx == PADDLE_L_COL) begin
            if (m_by >= pl0 && m_by < pl0 + PADDLE_LEN) begin
                ndx = -ndx;
                nx  = m_bx + ndx;
            end else miss_left = 1'b1;
        end
        if (miss_right || miss_left) begin
            if (miss_right) m_sl++;
            else m_sr++;
            m_conceded_right = miss_right;
            m_state = 2;
            m_ticks = 0;
        end else begin
            m_bx = nx;
            m_by = ny;
            m_dx = ndx;
            m_dy = ndy;
        end
    endtask

    task automatic model_tick(input bit ft, input bit sv, input bit ul,
                              input bit dl, input bit ur, input bit dr);
        int pl0, pr0;
        pl0 = m_pl;
        pr0 = m_pr;
        if (ft && m_state != 3) begin
            m_pl = clamp_pad(m_pl + int'(dl) - int'(ul));
            m_pr = clamp_pad(m_pr + int'(dr) - int'(ur));
        end
        case (m_state)
            0: if (sv) begin
                m_state = 1;
                m_ticks = 0;
            end
            1: if (ft) begin
                m_ticks++;
                if (m_ticks == BALL_DIV) begin
                    m_ticks = 0;
                    model_ball_step(pl0, pr0);
                end
            end
            2: if (ft) begin
                m_ticks++;
                if (m_ticks == POINT_FRAMES) begin
                    m_ticks = 0;
                    if (m_sl == WIN_SCORE || m_sr == WIN_SCORE) begin
                        m_state = 3;
                    end else begin
                        m_state = 0;
                        center_ball();
                        m_dx = m_conceded_right ? 1 : -1;
                    end
                end
            end
            default: if (sv) begin
                m_sl = 0;
                m_sr = 0;
                m_state = 0;
                center_ball();
                m_dx = 1;
            end
        endcase
    endtask

    // ---------------- driver / checker tasks ----------------
    task automatic pix(input int x, input int y);
        hori_cell = 10'(x);
        vert_cell = 10'(y);
        #1;
    endtask

    task automatic probe(input int x, input int y);
        pix(x, y);
        check($sformatf("on_ball(%0d,%0d)", x, y), on_ball,
              int'(m_state <= 1 && x == m_bx && y == m_by));
        check($sformatf("on_paddle_l(%0d,%0d)", x, y), on_paddle_l,
              int'(x == PADDLE_L_COL && y >= m_pl && y < m_pl + PADDLE_LEN));
        check($sformatf("on_paddle_r(%0d,%0d)", x, y), on_paddle_r,
              int'(x == PADDLE_R_COL && y >= m_pr && y < m_pr + PADDLE_LEN));
    endtask

    task automatic check_all();
        check("state", state, m_state);
        check("score_l", score_l, m_sl);
        check("score_r", score_r, m_sr);
        probe(m_bx, m_by);
        probe(PADDLE_L_COL, m_pl + int'($urandom_range(PADDLE_LEN)));
        probe(PADDLE_R_COL, m_pr + int'($urandom_range(PADDLE_LEN)));
    endtask

    task automatic cycle(input logic ft, input logic sv, input logic ul,
                         input logic dl, input logic ur, input logic dr);
        frame_tick = ft; serve = sv;
        up_l = ul; down_l = dl; up_r = ur; down_r = dr;
        @(posedge clk);
        model_tick(ft, sv, ul, dl, ur, dr);
        #1;
        check_all();
    endtask

    task automatic release_reset();
        frame_tick = 1'b0; serve = 1'b0;
        up_l = 1'b0; down_l = 1'b0; up_r = 1'b0; down_r = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        release_reset();
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int n_ball, n_pl, n_pr, budget, tgt_l, tgt_r;
        logic ft, sv, ul, dl, ur, dr;

        do_reset();
        // Idle after reset: nothing may move without a qualifying input.
        repeat (5) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Pixel sweep at the reset position: ball (20,15), paddles at 12.
        n_ball = 0; n_pl = 0; n_pr = 0;
        for (int x = 0; x <= GRID_W; x++) begin
            for (int y = 0; y <= GRID_H; y++) begin
                probe(x, y);
                n_ball += int'(on_ball);
                n_pl   += int'(on_paddle_l);
                n_pr   += int'(on_paddle_r);
            end
        end
        check("sweep_ball_hits", n_ball, 1);
        check("sweep_pad_l_hits", n_pl, PADDLE_LEN);
        check("sweep_pad_r_hits", n_pr, PADDLE_LEN);

        // Both left buttons held: paddle holds; then up_l saturates at 0.
        repeat (10) cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        pix(0, 12); check("both_held_top", on_paddle_l, 1);
        pix(0, 11); check("both_held_above", on_paddle_l, 0);
        repeat (20) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        pix(0, 0); check("up_sat_row0", on_paddle_l, 1);
        pix(0, 5); check("up_sat_row5", on_paddle_l, 1);
        pix(0, 6); check("up_sat_row6", on_paddle_l, 0);

        // Unattended right paddle: bounce at the bottom wall, then a miss.
        do_reset();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int t = 1; t <= 76; t++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (t == 56) begin
                pix(34, 29); check("bounce_row29", on_ball, 1);
            end
        end
        check("miss_score_l", score_l, 1);
        check("miss_state", state, 2);
        pix(38, 25); check("miss_ball_hidden", on_ball, 0);
        repeat (60) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("point_to_serve", state, 0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // serve with tick
        repeat (8) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset pulse between clock edges, mid-PLAY.
        #2 reset = 1'b0;
        #1;
        check("async_state", state, 0);
        check("async_score_l", score_l, 0);
        pix(20, 15); check("async_ball", on_ball, 1);
        pix(39, 17); check("async_pad_r", on_paddle_r, 1);
        release_reset();

        // Right paddle driven down saturates at 24 and returns the ball.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int t = 1; t <= 76; t++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            if (t == 12) begin
                pix(39, 24); check("pad_r_at24", on_paddle_r, 1);
                pix(39, 23); check("pad_r_above24", on_paddle_r, 0);
            end
        end
        check("hit_state", state, 1);
        check("hit_score_l", score_l, 0);
        check("hit_score_r", score_r, 0);
        pix(37, 24); check("hit_ball_37_24", on_ball, 1);

        // Randomized match: right paddle tracks the ball, left dodges it.
        do_reset();
        budget = 0;
        while (m_state != 3 && budget < 20000) begin
            ft = ($urandom_range(3) != 0);
            sv = (m_state == 0) ? ($urandom_range(3) == 0) : ($urandom_range(31) == 0);
            tgt_r = clamp_pad(m_by - PADDLE_LEN / 2);
            ur = (m_pr > tgt_r);
            dr = (m_pr < tgt_r);
            tgt_l = (m_by < GRID_H / 2) ? PAD_MAX : 0;
            ul = (m_pl > tgt_l);
            dl = (m_pl < tgt_l);
            if ($urandom_range(7) == 0) begin
                ul = 1'b1;
                dl = 1'b1;
            end
            cycle(ft, sv, ul, dl, ur, dr);
            budget++;
        end
        check("game_over_state", state, 3);
        check("game_over_score_r", score_r, WIN_SCORE);
        // GAME_OVER holds paddles and ball despite ticks and buttons.
        repeat (6) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("restart_state", state, 0);
        check("restart_score_r", score_r, 0);
        pix(20, 15); check("restart_ball", on_ball, 1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (20) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pong_game_core.md
PONG_GAME_CORE -- requirements
Module: pong_game_core

Interface
REQ-001 Parameter GRID_W, default 40, playfield width in cells (columns 0..GRID_W-1).
REQ-002 Parameter GRID_H, default 30, playfield height in cells (rows 0..GRID_H-1).
REQ-003 Parameter PADDLE_LEN, default 6, paddle height in cells.
REQ-004 Parameter PADDLE_L_COL, default 0, left paddle column.
REQ-005 Parameter PADDLE_R_COL, default 39, right paddle column.
REQ-006 Parameter BALL_DIV, default 4, frame ticks per ball step (>=1).
REQ-007 Parameter POINT_FRAMES, default 60, frame ticks held in POINT.
REQ-008 Parameter SCORE_W, default 4, score width; parameter WIN_SCORE, default 9, at most 2^SCORE_W-1.
REQ-009 clk  in  1  single system clock; all state on rising edge.
REQ-010 reset  in  1  asynchronous, active-low reset.
REQ-011 frame_tick  in  1  one-cycle pulse per video frame.
REQ-012 up_l, down_l, up_r, down_r  in  1 each  paddle buttons, already synchronised.
REQ-013 serve  in  1  one-cycle serve/restart request.
REQ-014 hori_cell, vert_cell  in  10 each  current pixel position in cell units.
REQ-015 on_paddle_l, on_paddle_r, on_ball  out  1 each  pixel-coverage flags.
REQ-016 score_l, score_r  out  SCORE_W each  current scores.
REQ-017 state  out  2  SERVE=0, PLAY=1, POINT=2, GAME_OVER=3.

Function
REQ-018 Paddle position = top row, range 0..GRID_H-PADDLE_LEN; updated only on frame_tick, not in GAME_OVER.
REQ-019 On frame_tick: up only -> decrement if >0; down only -> increment if <max; both or neither -> hold; saturates at both limits.
REQ-020 on_paddle_x = (hori_cell == column) AND top <= vert_cell <= top+PADDLE_LEN-1; combinational from registered state, zero latency.
REQ-021 on_ball = (hori_cell,vert_cell) == (ball_x,ball_y) AND state is SERVE or PLAY; deasserted in POINT and GAME_OVER.
REQ-022 SERVE: ball at (GRID_W/2, GRID_H/2), dy=down, step counter 0; serve -> PLAY.
REQ-023 PLAY: step counter counts frame_ticks; at BALL_DIV-1 it wraps to 0 and the ball takes one step.
REQ-024 Vertical step: y==0 moving up -> dy=down, y=1; y==GRID_H-1 moving down -> dy=up, y=GRID_H-2; else y+-1.
REQ-025 Horizontal step, moving right with x==PADDLE_R_COL-1: current y within right paddle -> dx=left, x=x-1; else miss.
REQ-026 Mirror of REQ-025 for moving left with x==PADDLE_L_COL+1 and left paddle; otherwise x+-1.
REQ-027 Vertical and horizontal rules apply independently in the same step (corner hits legal).
REQ-028 Miss: opponent score +1, ball position frozen, -> POINT, point counter 0.
REQ-029 POINT: counts frame_ticks; after POINT_FRAMES ticks -> GAME_OVER if either score == WIN_SCORE, else SERVE with dx toward the player who conceded.
REQ-030 GAME_OVER: scores and ball held; serve -> scores cleared, SERVE, dx=right.
REQ-031 serve outside SERVE/GAME_OVER ignored; serve coinciding with frame_tick in SERVE -> PLAY, that tick not counted.
REQ-032 Paddle update and ball step in the same tick: collision uses pre-update paddle position.

Reset
REQ-033 reset low asserts immediately regardless of clk, mid-operation included: state=SERVE, scores 0, ball (GRID_W/2, GRID_H/2), dx=right, dy=down, paddles (GRID_H-PADDLE_LEN)/2, counters 0.
REQ-034 After reset release, no state change until the first qualifying input.

Verification
REQ-035 Reset, serve, no buttons, 76 frame_ticks -> ball y bounces at 29 on step 14, miss on step 19 (y=25, paddle 12..17): score_l=1, state=POINT, on_ball=0.
REQ-036 As REQ-035 with down_r held -> right paddle saturates at 24 after 12 ticks; step 19 hits: dx=left, x=37, state=PLAY, scores 0.
REQ-037 up_l and down_l both held 10 ticks -> left paddle stays 12; up_l held 20 ticks -> 0, no underflow.
REQ-038 score_r=8, next miss by left player -> after 60 frame_ticks state=GAME_OVER; serve -> scores 0, state=SERVE.
REQ-039 reset pulsed low mid-PLAY between clock edges -> all outputs return to REQ-033 values asynchronously.
REQ-040 Pixel sweep with ball at (20,15), paddles at 12 -> on_ball only at (20,15); on_paddle_l only at column 0, rows 12..17.
